// File: rtl/g_2dbnc_n_pkg.sv
// Shared debounce definitions: FSM state encoding and parameter legality check,
// reused by every debounce macro in this family.
package g_2dbnc_n_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StPend = 1'b1
    } dbnc_state_e;

    localparam int unsigned SyncStagesMin = 2;
    localparam int unsigned SyncStagesMax = 4;

    // True when the synchroniser depth and filter length are legal for the counter width.
    function automatic bit dbnc_params_ok(int unsigned sync_stages, int unsigned cnt_w,
                                          int unsigned filt_len);
        longint unsigned cnt_max;
        cnt_max = (64'(1) << cnt_w) - 64'(1);
        return (sync_stages >= SyncStagesMin) && (sync_stages <= SyncStagesMax) &&
               (cnt_w >= 1) && (cnt_w <= 31) &&
               (filt_len >= 1) && (longint'(filt_len) <= cnt_max);
    endfunction

endpackage

// File: rtl/g_dbnc_chan.sv
// One debounce channel: synchroniser chain, IDLE/PEND filter FSM with sample
// counter, and registered assert/deassert pulses on the filtered active-low level.
module g_dbnc_chan
    import g_2dbnc_n_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned FILT_LEN    = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic raw_ni,
    output logic q_no,
    output logic fall_o,
    output logic rise_o
);

    if (!dbnc_params_ok(SYNC_STAGES, CNT_W, FILT_LEN)) begin : g_param_err
        $error("g_dbnc_chan: SYNC_STAGES or FILT_LEN out of range");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(FILT_LEN - 1);
    localparam bit               OneShot = (FILT_LEN == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    dbnc_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   fall_q, rise_q;

    // Reset to 1 so an idle (high) input never looks like an edge after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_ni};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (s != q_q) begin
                    if (OneShot && en_i) begin
                        q_d = s;
                    end else begin
                        state_d = StPend;
                        cnt_d   = en_i ? CNT_W'(1) : '0;
                    end
                end
            end
            StPend: begin
                if (s == q_q) begin
                    // Bounce back to the accepted level: discard the partial count.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (en_i) begin
                    if (cnt_q == CntLast) begin
                        q_d     = s;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            q_q     <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            fall_q  <= q_q & ~q_d;
            rise_q  <= ~q_q & q_d;
        end
    end

    assign q_no   = q_q;
    assign fall_o = fall_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/g_2dbnc_n.sv
// Dual-channel synchroniser and debounce filter for raw active-low inputs.
// Two independent g_dbnc_chan instances; no logic at this level.
module g_2dbnc_n
    import g_2dbnc_n_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned FILT_LEN    = 8
) (
    input  logic CK,
    input  logic CDN,
    input  logic EN,
    input  logic AN,
    input  logic BN,
    output logic QAN,
    output logic QBN,
    output logic FAN,
    output logic FBN,
    output logic RAN,
    output logic RBN
);

    g_dbnc_chan #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .FILT_LEN   (FILT_LEN)
    ) u_chan_a (
        .clk_i (CK),
        .rst_ni(CDN),
        .en_i  (EN),
        .raw_ni(AN),
        .q_no  (QAN),
        .fall_o(FAN),
        .rise_o(RAN)
    );

    g_dbnc_chan #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .FILT_LEN   (FILT_LEN)
    ) u_chan_b (
        .clk_i (CK),
        .rst_ni(CDN),
        .en_i  (EN),
        .raw_ni(BN),
        .q_no  (QBN),
        .fall_o(FBN),
        .rise_o(RBN)
    );

endmodule
